// File: rtl/rv32_div_pkg.sv
// -----------------------------------------------------------------------------
// rv32_div_pkg
// Shared types and constants for the iterative RV32M divider (div_iter).
//   div_op_e    : operation encoding, taken directly from funct3[1:0]
//   div_state_e : sequencer states of the divider
//   DIV_ZERO_Q  : architected quotient for division by zero
//   INT_MIN     : most negative 32-bit value, the signed-overflow dividend
// -----------------------------------------------------------------------------
package rv32_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // funct3[0] clear means the signed flavour (DIV / REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // funct3[1] set means the remainder is the architected result.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on magnitudes.
//   rem         : partial remainder before this step
//   dq          : shift register, remaining dividend bits in the top,
//                 resolved quotient bits accumulating in the bottom
//   divisor_mag : unsigned divisor magnitude
//   rem_next    : partial remainder after this step
//   dq_next     : dq shifted left with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dq,
  input  logic [XLEN-1:0] divisor_mag,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dq_next
);

  // The shifted remainder is kept one bit wider for the compare. In practice
  // the top bit is always zero here: the remainder entering a step is either
  // below a divisor of at most 2^(XLEN-1), or (for larger divisors) still just
  // the leading dividend bits, which never reach bit XLEN-1 before the final
  // step. Keeping it makes the compare correct without relying on that.
  logic [XLEN:0] rem_wide;
  logic          rem_ge;

  always_comb begin
    rem_wide = {rem, dq[XLEN-1]};
    // Unsigned magnitude comparator.
    rem_ge   = (rem_wide >= {1'b0, divisor_mag});
    rem_next = rem_ge ? (rem_wide[XLEN-1:0] - divisor_mag) : rem_wide[XLEN-1:0];
    dq_next  = {dq[XLEN-2:0], rem_ge};
  end

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle restoring divider for RV32M DIV / DIVU / REM / REMU.
// One quotient bit is resolved per cycle; the execute stage stalls on it
// through a start/valid handshake.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     request, sampled only while o_ready=1
//   i_op        div_op_e (funct3[1:0])
//   i_dividend  rs1
//   i_divisor   rs2
//   i_flush     abort; wins over a same-cycle i_start
//   o_ready     idle, can accept i_start
//   o_busy      operation in progress (BUSY or FIX)
//   o_valid     one-cycle pulse, o_result valid
//   o_result    quotient or remainder; held until the next completion
//
// Latency from the edge sampling i_start: divide-by-zero and signed overflow
// resolve at that edge (o_valid after edge 1); every other case spends
// 32 BUSY cycles plus one FIX cycle (o_valid after edge 34).
// -----------------------------------------------------------------------------
module div_iter
  import rv32_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [XLEN-1:0] ZERO_Q_X  = XLEN'(DIV_ZERO_Q);
  localparam logic [XLEN-1:0] INT_MIN_X = XLEN'(INT_MIN);

  logic [1:0]      state_reg, state_next;
  logic            op_rem_reg, op_rem_next;
  logic [XLEN-1:0] rem_reg, rem_next;
  logic [XLEN-1:0] dq_reg, dq_next;
  logic [XLEN-1:0] dmag_reg, dmag_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;
  logic [XLEN-1:0] result_reg, result_next;

  // Request decode (only meaningful while idle).
  logic            req_signed;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_mag;
  logic [XLEN-1:0] divisor_mag;
  logic            div_by_zero;
  logic            signed_ovf;

  // Iteration datapath and sign fix-up.
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_dq;
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem         (rem_reg),
    .dq          (dq_reg),
    .divisor_mag (dmag_reg),
    .rem_next    (step_rem),
    .dq_next     (step_dq)
  );

  always_comb begin
    req_signed   = op_is_signed(i_op);
    dividend_neg = req_signed & i_dividend[XLEN-1];
    divisor_neg  = req_signed & i_divisor[XLEN-1];
    // Negating INT_MIN yields INT_MIN again, which is the correct magnitude
    // once treated as unsigned.
    dividend_mag = dividend_neg ? (~i_dividend + 1'b1) : i_dividend;
    divisor_mag  = divisor_neg  ? (~i_divisor  + 1'b1) : i_divisor;
    div_by_zero  = (i_divisor == '0);
    signed_ovf   = req_signed && (i_dividend == INT_MIN_X) && (i_divisor == '1);
  end

  always_comb begin
    quot_fixed = neg_q_reg ? (~dq_reg  + 1'b1) : dq_reg;
    rem_fixed  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_comb begin
    state_next  = state_reg;
    op_rem_next = op_rem_reg;
    rem_next    = rem_reg;
    dq_next     = dq_reg;
    dmag_next   = dmag_reg;
    count_next  = count_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          op_rem_next = op_is_rem(i_op);
          rem_next    = '0;
          dq_next     = dividend_mag;
          dmag_next   = divisor_mag;
          count_next  = CW'(XLEN - 1);
          neg_q_next  = dividend_neg ^ divisor_neg;
          neg_r_next  = dividend_neg;
          if (div_by_zero) begin
            // Architected divide-by-zero: quotient all ones, remainder = rs1.
            result_next = op_is_rem(i_op) ? i_dividend : ZERO_Q_X;
            state_next  = ST_DONE;
          end else if (signed_ovf) begin
            result_next = op_is_rem(i_op) ? '0 : INT_MIN_X;
            state_next  = ST_DONE;
          end else begin
            state_next  = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        rem_next = step_rem;
        dq_next  = step_dq;
        if (count_reg == '0) begin
          state_next = ST_FIX;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end

      ST_FIX: begin
        // Quotient sign follows the operand signs, remainder sign follows
        // the dividend (truncating division); unsigned ops never negate.
        result_next = op_rem_reg ? rem_fixed : quot_fixed;
        state_next  = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort: drop any same-cycle start and keep the last delivered result.
    if (i_flush) begin
      state_next  = ST_IDLE;
      result_next = result_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      op_rem_reg <= 1'b0;
      rem_reg    <= '0;
      dq_reg     <= '0;
      dmag_reg   <= '0;
      count_reg  <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_rem_reg <= op_rem_next;
      rem_reg    <= rem_next;
      dq_reg     <= dq_next;
      dmag_reg   <= dmag_next;
      count_reg  <= count_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    o_ready  = (state_reg == ST_IDLE);
    o_busy   = (state_reg == ST_BUSY) || (state_reg == ST_FIX);
    o_valid  = (state_reg == ST_DONE);
    o_result = result_reg;
  end

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter: directed RV32M cases, randomized
// operations against an arithmetic reference model, flush, ignored start
// and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_div_iter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_flush;
  logic        o_ready;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = 32'h0;

  div_iter #(
    .XLEN (32)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge with the divider idle. Issues one request, waits for
  // o_valid (bounded), checks latency, result and the single-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp     = ref_div(op, a, b);
    exp_lat = ref_latency(op, a, b);
    i_op       = op;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_start = 1'b0;
    if (exp_lat > 1) begin
      check_eq({tag, " busy"}, {31'h0, o_busy}, 32'h1);
      check_eq({tag, " ready"}, {31'h0, o_ready}, 32'h0);
    end
    while (!o_valid && lat < 60) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    check_eq({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " res"}, o_result, exp);
    $display("op=%0d a=%08h b=%08h result=%08h expect=%08h lat=%0d",
             op, a, b, o_result, exp, lat);
    last_res = exp;
    @(negedge i_clk);
    check_eq({tag, " pulse"}, {31'h0, o_valid}, 32'h0);
    check_eq({tag, " hold"}, o_result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          vcount;
    int          lat;
    int          first_lat;
    logic [31:0] first_res;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_flush    = 1'b0;
    i_op       = 2'b00;
    i_dividend = 32'h0;
    i_divisor  = 32'h0;
    repeat (3) @(negedge i_clk);
    check_eq("rst ready",  {31'h0, o_ready}, 32'h1);
    check_eq("rst busy",   {31'h0, o_busy},  32'h0);
    check_eq("rst valid",  {31'h0, o_valid}, 32'h0);
    check_eq("rst result", o_result, 32'h0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Directed cases.
    run_op("divu 100/7",   2'b01, 32'd100, 32'd7);
    run_op("remu 100/7",   2'b11, 32'd100, 32'd7);
    run_op("div -7/2",     2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2",     2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("rem 7/-2",     2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("divu 5/0",     2'b01, 32'd5, 32'h0);
    run_op("rem min/0",    2'b10, 32'h8000_0000, 32'h0);
    run_op("div ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu big",     2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("div min/2",    2'b00, 32'h8000_0000, 32'd2);
    run_op("divu min/-1",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized operations with a bias towards corner divisors.
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       begin ra = 32'h8000_0000; rb = $urandom; end
        5:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb);
    end

    // Flush during BUSY: back to idle next edge, no completion, result kept.
    i_op = 2'b01; i_dividend = 32'hDEAD_BEEF; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    check_eq("flush ready", {31'h0, o_ready}, 32'h1);
    check_eq("flush busy",  {31'h0, o_busy},  32'h0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) vcount++;
      @(negedge i_clk);
    end
    check_eq("flush no valid", 32'(vcount), 32'h0);
    check_eq("flush result kept", o_result, last_res);
    $display("flush during busy: valids=%0d result=%08h", vcount, o_result);
    run_op("divu 9/3", 2'b01, 32'd9, 32'd3);

    // Flush and start together while idle: the start is dropped.
    i_op = 2'b01; i_dividend = 32'd50; i_divisor = 32'd5;
    i_start = 1'b1; i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    check_eq("flush+start ready", {31'h0, o_ready}, 32'h1);
    check_eq("flush+start busy",  {31'h0, o_busy},  32'h0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) vcount++;
      @(negedge i_clk);
    end
    check_eq("flush+start no valid", 32'(vcount), 32'h0);
    $display("flush with start: valids=%0d", vcount);

    // A start while busy is ignored: one completion with the first operands.
    i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd10; i_start = 1'b1;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_start = 1'b0;
    vcount = 0; first_lat = 0; first_res = 32'h0;
    for (int c = 0; c < 50; c++) begin
      if (lat == 5) begin
        i_op = 2'b11; i_dividend = 32'd7; i_divisor = 32'd7; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_valid) begin
        vcount++;
        if (vcount == 1) begin
          first_lat = lat;
          first_res = o_result;
        end
      end
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check_eq("ignored start valids", 32'(vcount), 32'h1);
    check_eq("ignored start lat", 32'(first_lat), 32'd34);
    check_eq("ignored start res", first_res, 32'd100);
    check_eq("ignored start hold", o_result, 32'd100);
    $display("start while busy: valids=%0d lat=%0d result=%08h", vcount, first_lat, first_res);

    // Asynchronous reset mid-BUSY: outputs return to reset values at once.
    i_op = 2'b01; i_dividend = 32'h0001_0000; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("arst ready",  {31'h0, o_ready}, 32'h1);
    check_eq("arst busy",   {31'h0, o_busy},  32'h0);
    check_eq("arst valid",  {31'h0, o_valid}, 32'h0);
    check_eq("arst result", o_result, 32'h0);
    $display("async reset mid-busy: ready=%0b busy=%0b result=%08h", o_ready, o_busy, o_result);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) vcount++;
      @(negedge i_clk);
    end
    check_eq("arst no valid", 32'(vcount), 32'h0);
    run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sits beside the ALU; the execute stage stalls on it through a start/valid handshake.
- Each iteration performs one magnitude compare-and-subtract step, resolving one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request; sampled only while o_ready=1
- i_op  input  2  div_op_e: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- i_dividend  input  XLEN  rs1
- i_divisor  input  XLEN  rs2
- i_flush  input  1  abort current operation
- o_ready  output  1  idle, can accept i_start
- o_busy  output  1  operation in progress
- o_valid  output  1  one-cycle pulse, o_result valid
- o_result  output  XLEN  quotient or remainder per latched op

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_busy=0, o_valid=0, o_result=0, all internal registers 0.
- Clock/reset: one clock; reset is asynchronous and active-low.
- States:
  - IDLE: o_ready=1. i_start=1 latches op and operands. Divisor==0 goes to DONE. Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF goes to DONE. Otherwise goes to BUSY with count=XLEN-1.
  - BUSY: o_busy=1, o_ready=0. Each cycle: rem={rem[XLEN-2:0],dq[XLEN-1]}, dq<<=1. If rem>=|divisor| (unsigned compare), rem-=|divisor| and dq[0]=1. When count==0, go to FIX; otherwise count-=1.
  - FIX: negate quotient if operand signs differ (signed ops only). Negate remainder if dividend is negative (signed ops only). Select the result per op, then go to DONE.
  - DONE: o_valid=1 for exactly one cycle, then IDLE.
- Signed ops take magnitudes at latch time; |0x80000000| is 0x80000000 treated as unsigned.
- Latency, counted from the edge that samples i_start:
  - Normal case: o_valid high in the cycle following edge 34 (1 latch + 32 BUSY + 1 FIX).
  - Special cases: o_valid high after edge 1.
- o_result holds its value after o_valid drops, until the next DONE. o_result changes only on entry to DONE.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU); remainder=dividend.
  - Signed overflow: quotient=0x80000000, remainder=0.
- i_start while o_ready=0 is ignored; no queueing.
- i_flush in any state returns to IDLE on the next edge with no o_valid. i_flush has priority over i_start in the same cycle: the start is dropped.
- Async reset mid-operation aborts immediately; no o_valid is produced.
- o_busy=1 in BUSY and FIX. o_ready=1 only in IDLE.

Decomposition:
- Package rv32_div_pkg:
  - div_op_e
  - div_state_e (IDLE, BUSY, FIX, DONE)
  - constants DIV_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000
- Sub-module div_step (combinational), one restoring iteration:
  - inputs: rem, dq, divisor magnitude
  - outputs: next rem, next dq
  - contains the unsigned magnitude comparator

Test Plan:
- DIVU 100/7 -> o_valid exactly 34 cycles after start, o_result=14; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/0 -> 0x80000000; o_valid 1 cycle after start.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; fast path.
- Start DIVU, pulse i_flush at BUSY cycle 10 -> IDLE next edge, no o_valid. A new DIVU 9/3 then returns 3 with full latency. i_start during BUSY is ignored: o_result unchanged, single o_valid.
- Deassert i_rst_n mid-BUSY -> all outputs return to reset values immediately. After release, a DIVU 0xFFFFFFFF/1 returns 0xFFFFFFFF.
